// File: rtl/time_set_controller.sv
// time_set_controller: turns the mode/increment buttons into new hour and
// minute values for the timekeeping counter. It captures the current time on
// entry to set mode, edits hours and then minutes, and issues a one-cycle
// load strobe when the edit is committed.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal timekeeping, increment ignored, waiting for mode press
// SET_HOUR | editing hours, blink on the hour field
// SET_MIN  | editing minutes, next mode press commits via load_en
module time_set_controller #(
    parameter int HOUR_MAX      = 23,
    parameter int MINUTE_MAX    = 59,
    parameter int REPEAT_DELAY  = 2,
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic       clock_1_second,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [6:0] cur_hour,
    input  logic [6:0] cur_minute,
    output logic [1:0] set_mode,
    output logic [6:0] edit_hour,
    output logic [6:0] edit_minute,
    output logic       blink,
    output logic       load_en,
    output logic [6:0] load_hour,
    output logic [6:0] load_minute
);

    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam int IDLE_W = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [6:0]        HOUR_LAST   = 7'(HOUR_MAX);
    localparam logic [6:0]        MINUTE_LAST = 7'(MINUTE_MAX);
    localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(REPEAT_DELAY);
    localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic              btn_mode_q, btn_inc_q;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [6:0]        edit_hour_nxt, edit_minute_nxt;
    logic [6:0]        load_hour_nxt, load_minute_nxt;
    logic              load_en_nxt, blink_nxt;
    logic              mode_press, inc_press, inc_step, any_btn, timeout, state_change;

    assign set_mode = state;

    // Register all state and registered outputs; synchronous clear to zero.
    always_ff @(posedge clock_1_second) begin
        if (reset) begin
            state       <= RUN;
            btn_mode_q  <= 1'b0;
            btn_inc_q   <= 1'b0;
            hold_cnt    <= '0;
            idle_cnt    <= '0;
            edit_hour   <= '0;
            edit_minute <= '0;
            load_hour   <= '0;
            load_minute <= '0;
            load_en     <= 1'b0;
            blink       <= 1'b0;
        end else begin
            state       <= state_nxt;
            btn_mode_q  <= btn_mode;
            btn_inc_q   <= btn_inc;
            hold_cnt    <= hold_cnt_nxt;
            idle_cnt    <= idle_cnt_nxt;
            edit_hour   <= edit_hour_nxt;
            edit_minute <= edit_minute_nxt;
            load_hour   <= load_hour_nxt;
            load_minute <= load_minute_nxt;
            load_en     <= load_en_nxt;
            blink       <= blink_nxt;
        end
    end

    // Next-state, edit arithmetic, auto-repeat/idle counters and blink.
    always_comb begin
        state_nxt       = state;
        edit_hour_nxt   = edit_hour;
        edit_minute_nxt = edit_minute;
        load_hour_nxt   = load_hour;
        load_minute_nxt = load_minute;
        load_en_nxt     = 1'b0;

        mode_press = btn_mode & ~btn_mode_q;
        inc_press  = btn_inc & ~btn_inc_q;
        inc_step   = inc_press | (btn_inc & (hold_cnt == HOLD_SAT));
        any_btn    = btn_mode | btn_inc;
        timeout    = ~any_btn & (idle_cnt == IDLE_LAST);

        case (state)
            RUN: begin
                if (mode_press) begin
                    state_nxt       = SET_HOUR;
                    edit_hour_nxt   = (cur_hour > HOUR_LAST) ? 7'd0 : cur_hour;
                    edit_minute_nxt = (cur_minute > MINUTE_LAST) ? 7'd0 : cur_minute;
                end
            end
            SET_HOUR: begin
                if (mode_press) begin
                    state_nxt = SET_MIN;
                end else if (timeout) begin
                    state_nxt = RUN;
                end else if (inc_step) begin
                    edit_hour_nxt = (edit_hour == HOUR_LAST) ? 7'd0 : edit_hour + 7'd1;
                end
            end
            SET_MIN: begin
                if (mode_press) begin
                    state_nxt       = RUN;
                    load_hour_nxt   = edit_hour;
                    load_minute_nxt = edit_minute;
                    load_en_nxt     = 1'b1;
                end else if (timeout) begin
                    state_nxt = RUN;
                end else if (inc_step) begin
                    edit_minute_nxt = (edit_minute == MINUTE_LAST) ? 7'd0 : edit_minute + 7'd1;
                end
            end
            default: state_nxt = RUN;
        endcase

        state_change = (state_nxt != state);

        if (!btn_inc || state_change) begin
            hold_cnt_nxt = '0;
        end else if (hold_cnt < HOLD_SAT) begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt_nxt = hold_cnt;
        end

        if (state_change || any_btn || state == RUN) begin
            idle_cnt_nxt = '0;
        end else begin
            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
        end

        // Entry cycle of a set state shows the field steadily, then it blinks.
        if (state_change || state_nxt == RUN) begin
            blink_nxt = 1'b0;
        end else begin
            blink_nxt = ~blink;
        end
    end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: entry capture, wrap, auto-repeat,
// commit strobe, timeout, mode/inc collision and reset mid-edit.
module tb_time_set_controller;

    logic       clock_1_second = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc;
    logic [6:0] cur_hour, cur_minute;
    logic [1:0] set_mode;
    logic [6:0] edit_hour, edit_minute, load_hour, load_minute;
    logic       blink, load_en;

    int errors = 0;
    int checks = 0;

    time_set_controller dut (
        .clock_1_second (clock_1_second),
        .reset          (reset),
        .btn_mode       (btn_mode),
        .btn_inc        (btn_inc),
        .cur_hour       (cur_hour),
        .cur_minute     (cur_minute),
        .set_mode       (set_mode),
        .edit_hour      (edit_hour),
        .edit_minute    (edit_minute),
        .blink          (blink),
        .load_en        (load_en),
        .load_hour      (load_hour),
        .load_minute    (load_minute)
    );

    always #5 clock_1_second = ~clock_1_second;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one active edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clock_1_second);
        #1;
    endtask

    task automatic inc_pulse();
        btn_inc = 1'b1;
        tick();
        btn_inc = 1'b0;
        tick();
    endtask

    task automatic mode_pulse();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        cur_hour = 7'd0; cur_minute = 7'd0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_mode", int'(set_mode), 0);
        chk("rst_edit_h", int'(edit_hour), 0);
        chk("rst_edit_m", int'(edit_minute), 0);
        chk("rst_load_en", int'(load_en), 0);
        chk("rst_load_h", int'(load_hour), 0);
        chk("rst_blink", int'(blink), 0);

        // entry capture 14:37 and blink pattern
        cur_hour = 7'd14; cur_minute = 7'd37;
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        chk("entry_mode", int'(set_mode), 1);
        chk("entry_h", int'(edit_hour), 14);
        chk("entry_m", int'(edit_minute), 37);
        chk("entry_blink", int'(blink), 0);
        tick();
        chk("blink_1", int'(blink), 1);
        tick();
        chk("blink_2", int'(blink), 0);

        // hour wrap 22 -> 23 -> 0
        for (int i = 0; i < 8; i++) inc_pulse();
        chk("hour_22", int'(edit_hour), 22);
        inc_pulse();
        chk("hour_23", int'(edit_hour), 23);
        inc_pulse();
        chk("hour_wrap", int'(edit_hour), 0);

        // into SET_MIN, minute wrap 58 -> 59 -> 0
        mode_pulse();
        chk("setmin_mode", int'(set_mode), 2);
        chk("setmin_m", int'(edit_minute), 37);
        for (int i = 0; i < 21; i++) inc_pulse();
        chk("min_58", int'(edit_minute), 58);
        inc_pulse();
        chk("min_59", int'(edit_minute), 59);
        inc_pulse();
        chk("min_wrap", int'(edit_minute), 0);

        // auto-repeat from 10 with btn_inc held 6 cycles
        for (int i = 0; i < 10; i++) inc_pulse();
        chk("min_10", int'(edit_minute), 10);
        btn_inc = 1'b1;
        tick(); chk("rep_1", int'(edit_minute), 11);
        tick(); chk("rep_2", int'(edit_minute), 11);
        tick(); chk("rep_3", int'(edit_minute), 12);
        tick(); chk("rep_4", int'(edit_minute), 13);
        tick(); chk("rep_5", int'(edit_minute), 14);
        tick(); chk("rep_6", int'(edit_minute), 15);
        btn_inc = 1'b0;
        tick();
        chk("rep_release", int'(edit_minute), 15);

        // commit 00:15
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        chk("c1_load_en", int'(load_en), 1);
        chk("c1_load_h", int'(load_hour), 0);
        chk("c1_load_m", int'(load_minute), 15);
        chk("c1_mode", int'(set_mode), 0);
        tick();
        chk("c1_load_en_off", int'(load_en), 0);

        // mode, mode, mode with 07:45 captured
        cur_hour = 7'd7; cur_minute = 7'd45;
        mode_pulse();
        chk("c2_mode_h", int'(set_mode), 1);
        mode_pulse();
        chk("c2_mode_m", int'(set_mode), 2);
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        chk("c2_load_en", int'(load_en), 1);
        chk("c2_load_h", int'(load_hour), 7);
        chk("c2_load_m", int'(load_minute), 45);
        chk("c2_mode", int'(set_mode), 0);
        tick();
        chk("c2_load_en_off", int'(load_en), 0);
        chk("c2_held_h", int'(load_hour), 7);
        chk("c2_held_m", int'(load_minute), 45);
        chk("c2_run", int'(set_mode), 0);

        // timeout with out-of-range capture values
        cur_hour = 7'd30; cur_minute = 7'd70;
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        chk("cap_h_clamp", int'(edit_hour), 0);
        chk("cap_m_clamp", int'(edit_minute), 0);
        for (int i = 1; i < 30; i++) begin
            tick();
            chk("to_wait_mode", int'(set_mode), 1);
            chk("to_wait_load_en", int'(load_en), 0);
        end
        tick();
        chk("to_mode", int'(set_mode), 0);
        chk("to_load_en", int'(load_en), 0);
        chk("to_load_h", int'(load_hour), 7);
        chk("to_load_m", int'(load_minute), 45);
        chk("to_blink", int'(blink), 0);

        // mode and inc together: mode wins, no edit
        cur_hour = 7'd5; cur_minute = 7'd20;
        mode_pulse();
        inc_pulse();
        chk("coll_h6", int'(edit_hour), 6);
        btn_mode = 1'b1; btn_inc = 1'b1;
        tick();
        btn_mode = 1'b0; btn_inc = 1'b0;
        chk("coll_mode", int'(set_mode), 2);
        chk("coll_h", int'(edit_hour), 6);
        chk("coll_m", int'(edit_minute), 20);
        tick();
        chk("coll_m_after", int'(edit_minute), 20);

        // reset during SET_MIN
        reset = 1'b1;
        tick();
        chk("mr_mode", int'(set_mode), 0);
        chk("mr_edit_h", int'(edit_hour), 0);
        chk("mr_edit_m", int'(edit_minute), 0);
        chk("mr_load_en", int'(load_en), 0);
        chk("mr_load_h", int'(load_hour), 0);
        chk("mr_load_m", int'(load_minute), 0);
        chk("mr_blink", int'(blink), 0);
        reset = 1'b0;
        tick();
        chk("mr_after_load_en", int'(load_en), 0);
        chk("mr_after_mode", int'(set_mode), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
